timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of tick_count.
REQ-002 SHALL have port: clk  in  1  single clock for all logic.
REQ-003 SHALL have port: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: cmd_valid  in  1  start request, accepted when cmd_valid && cmd_ready.
REQ-005 SHALL have port: cmd_ready  out  1  high only in IDLE.
REQ-006 SHALL have port: cmd_period  in  32  timer period in clocks, minus one.
REQ-007 SHALL have port: cmd_cont  in  1  1 = periodic, 0 = one-shot.
REQ-008 SHALL have port: cmd_stop  in  1  level stop request, honoured in RUN only.
REQ-009 SHALL have ports: tmr_address out 3, tmr_chipselect out 1, tmr_write_n out 1, tmr_writedata out 16 (Avalon master to the 16-bit interval timer slave); tmr_readdata in 16; tmr_irq in 1.
REQ-010 SHALL have ports: busy out 1 (state != IDLE); tick_pulse out 1 (one-cycle pulse per timeout); tick_count out CNT_W (timeouts since start); done out 1 (one-cycle pulse on return to IDLE).
REQ-011 SHALL have ports, present only with TIMER_CTRL_SNAPSHOT_EN: snap_req in 1, snap_value out 32, snap_valid out 1.

Function
REQ-012 Timer map SHALL be: 0 status (write clears timeout), 1 control {STOP,START,CONT,ITO}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h; no waitrequest; readdata registered, valid the cycle after the address is presented.
REQ-013 Each access SHALL assert tmr_chipselect for exactly one cycle; tmr_write_n = 0 for writes, 1 otherwise; idle bus: chipselect 0, write_n 1, address 0, writedata 0.
REQ-014 States SHALL be IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, STP, STP_CLR, plus SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP under the macro.
REQ-015 On accept: latch period and cont, clear tick_count, then WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTL (addr 1, 0x5 | cont<<1) -> RUN; IDLE to RUN SHALL take 4 cycles.
REQ-016 cmd_period == 0 SHALL be replaced by 1 before latching.
REQ-017 RUN priority SHALL be: cmd_stop, then tmr_irq, then snap_req.
REQ-018 RUN with tmr_irq: CLR writes addr 0 data 0, pulses tick_pulse in the same cycle, and increments tick_count, which wraps at 2^CNT_W-1 -> 0.
REQ-019 After CLR: cont=1 returns to RUN; cont=0 enters IDLE with done pulsed in the IDLE-entry cycle.
REQ-020 RUN with cmd_stop: STP writes addr 1 data 0x8; STP_CLR writes addr 0; then IDLE with done; no tick_pulse, even if irq is simultaneous.
REQ-021 cmd_valid and cmd_stop outside their states SHALL be ignored; cmd_* SHALL be sampled only at accept.

Reset
REQ-022 Reset SHALL force IDLE; cmd_ready 1; busy, tick_pulse, done 0; tick_count 0; bus idle per REQ-013; snap_value 0; snap_valid 0.
REQ-023 Reset mid-sequence SHALL abandon the access immediately with no further bus cycles; the timer is reset by the same reset_n.

Configuration
REQ-024 With TIMER_CTRL_SNAPSHOT_EN defined, RUN with snap_req: SNAP_WR (write addr 4) -> SNAP_RL (read addr 4) -> SNAP_RH (read addr 5, capture readdata as snap_value[15:0]) -> SNAP_CAP (capture snap_value[31:16], pulse snap_valid) -> RUN.
REQ-025 An irq arriving during a snapshot sequence SHALL stay pending and be serviced on return to RUN.
REQ-026 Without the macro, snapshot ports and states SHALL be absent and RUN SHALL react only to cmd_stop and tmr_irq.

Verification
REQ-027 Period 0x0001_86A0, cont=1 -> writes (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles; RUN at accept+4.
REQ-028 cont=0, period 49, irq after 50 clocks -> write (0,0), one tick_pulse, tick_count=1, done, then cmd_ready=1.
REQ-029 cont=1, five irqs, then cmd_stop -> tick_count=5; writes (1,0x0008), (0,0); done; busy=0.
REQ-030 cmd_stop and tmr_irq in the same RUN cycle -> STP taken, no tick_pulse, tick_count unchanged.
REQ-031 CNT_W=4, sixteen timeouts -> tick_count wraps 15 -> 0.
REQ-032 Macro defined, snap_req with timer readdata 0x1234 then 0x0005 -> snap_value=0x0005_1234, snap_valid pulse; irq during the sequence serviced afterward.

Source files
------------

// File: rtl/timer_ctrl.sv
// Sequencer driving a 16-bit Avalon interval timer: program, run, count timeouts.
// Optional snapshot readback is enabled by defining TIMER_CTRL_SNAPSHOT_EN.
module timer_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_cont,
  input  logic             cmd_stop,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq,
  output logic             busy,
  output logic             tick_pulse,
  output logic [CNT_W-1:0] tick_count,
  output logic             done
`ifdef TIMER_CTRL_SNAPSHOT_EN
  ,
  input  logic             snap_req,
  output logic [31:0]      snap_value,
  output logic             snap_valid
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTL,
    RUN,
    CLR,
    STP,
    STP_CLR
`ifdef TIMER_CTRL_SNAPSHOT_EN
    ,
    SNAP_WR,
    SNAP_RL,
    SNAP_RH,
    SNAP_CAP
`endif
  } state_t;

  state_t      state;
  state_t      next;
  logic [31:0] period_q;
  logic        cont_q;
  logic        irq_hit;
  logic        accept;

  assign accept     = (state == IDLE) && cmd_valid;
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign tick_pulse = (state == CLR);

`ifdef TIMER_CTRL_SNAPSHOT_EN
  logic irq_pend;
  logic in_snap;

  assign in_snap = (state == SNAP_WR) || (state == SNAP_RL) ||
                   (state == SNAP_RH) || (state == SNAP_CAP);
  assign irq_hit = tmr_irq || irq_pend;

  // irq seen mid-snapshot is held until RUN can service it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend   <= 1'b0;
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (state == CLR || state == STP)
        irq_pend <= 1'b0;
      else if (in_snap && tmr_irq)
        irq_pend <= 1'b1;
      if (state == SNAP_RH)
        snap_value[15:0] <= tmr_readdata;
      if (state == SNAP_CAP)
        snap_value[31:16] <= tmr_readdata;
      snap_valid <= (state == SNAP_CAP);
    end
  end
`else
  wire unused_rd = ^tmr_readdata;
  assign irq_hit = tmr_irq;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= '0;
      cont_q     <= 1'b0;
      tick_count <= '0;
      done       <= 1'b0;
    end else begin
      if (accept) begin
        period_q   <= (cmd_period == 32'd0) ? 32'd1 : cmd_period;
        cont_q     <= cmd_cont;
        tick_count <= '0;
      end else if (state == CLR) begin
        tick_count <= tick_count + CNT_W'(1);
      end
      done <= ((state == CLR) && !cont_q) || (state == STP_CLR);
    end
  end

  always_comb begin
    next           = state;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    unique case (state)
      IDLE: begin
        if (cmd_valid)
          next = WR_PL;
      end
      WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd2;
        tmr_writedata  = period_q[15:0];
        next           = WR_PH;
      end
      WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd3;
        tmr_writedata  = period_q[31:16];
        next           = WR_CTL;
      end
      WR_CTL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = {14'd0, cont_q, 1'b0} | 16'h0005;
        next           = RUN;
      end
      RUN: begin
        if (cmd_stop)
          next = STP;
        else if (irq_hit)
          next = CLR;
`ifdef TIMER_CTRL_SNAPSHOT_EN
        else if (snap_req)
          next = SNAP_WR;
`endif
      end
      CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        next           = cont_q ? RUN : IDLE;
      end
      STP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = 16'h0008;
        next           = STP_CLR;
      end
      STP_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        next           = IDLE;
      end
`ifdef TIMER_CTRL_SNAPSHOT_EN
      SNAP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd4;
        next           = SNAP_RL;
      end
      SNAP_RL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 3'd4;
        next           = SNAP_RH;
      end
      SNAP_RH: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 3'd5;
        next           = SNAP_CAP;
      end
      SNAP_CAP: begin
        next = RUN;
      end
`endif
      default: begin
        next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: bus accesses scoreboarded from a queue,
// status outputs checked with immediate assertions.
module tb_timer_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_period;
  logic          cmd_cont;
  logic          cmd_stop;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect;
  logic          tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata;
  logic          tmr_irq;
  logic          busy;
  logic          tick_pulse;
  logic [CW-1:0] tick_count;
  logic          done;
`ifdef TIMER_CTRL_SNAPSHOT_EN
  logic          snap_req;
  logic [31:0]   snap_value;
  logic          snap_valid;
`endif

  int total = 0;
  int fails = 0;
  int cnt   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_got;
  logic [19:0] mon_exp;

  always #5 clk = ~clk;

  timer_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_period     (cmd_period),
    .cmd_cont       (cmd_cont),
    .cmd_stop       (cmd_stop),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .busy           (busy),
    .tick_pulse     (tick_pulse),
    .tick_count     (tick_count),
    .done           (done)
`ifdef TIMER_CTRL_SNAPSHOT_EN
    ,
    .snap_req       (snap_req),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid)
`endif
  );

`ifdef TIMER_CTRL_SNAPSHOT_EN
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? 16'h1234 :
                      (tmr_address == 3'd5) ? 16'h0005 : 16'h0000;
    else
      tmr_readdata <= 16'h0000;
  end
`else
  assign tmr_readdata = 16'h0000;
`endif

  // every bus access must match the next queued expectation
  always @(negedge clk) begin
    if (reset_n && tmr_chipselect) begin
      mon_got = {tmr_write_n, tmr_address, tmr_writedata};
      total++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL bus_extra got %h want none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        assert (mon_got === mon_exp) else begin
          fails++;
          $error("FAIL bus_access got %h want %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic wn, input logic [2:0] a,
                     input logic [15:0] d);
    exp_q.push_back({wn, a, d});
  endtask

  task automatic start(input logic [31:0] p, input logic c,
                       input logic [31:0] pe);
    acc(1'b0, 3'd2, pe[15:0]);
    acc(1'b0, 3'd3, pe[31:16]);
    acc(1'b0, 3'd1, c ? 16'h0007 : 16'h0005);
    cmd_valid  = 1'b1;
    cmd_period = p;
    cmd_cont   = c;
    cyc(1);
    cmd_valid  = 1'b0;
    cmd_period = $urandom;
    cmd_cont   = ~c;
    cnt        = 0;
    chk("busy_prog", 32'(busy), 32'd1);
    chk("ready_prog", 32'(cmd_ready), 32'd0);
    cyc(3);
    chk("tick_count_start", 32'(tick_count), 32'd0);
  endtask

  task automatic irq(input logic c);
    acc(1'b0, 3'd0, 16'h0000);
    tmr_irq = 1'b1;
    cyc(1);
    chk("tick_pulse", 32'(tick_pulse), 32'd1);
    tmr_irq = 1'b0;
    cyc(1);
    cnt = (cnt + 1) % 16;
    chk("tick_count", 32'(tick_count), 32'(cnt));
    chk("tick_pulse_low", 32'(tick_pulse), 32'd0);
    chk("done_after_clr", 32'(done), c ? 32'd0 : 32'd1);
  endtask

  task automatic stop(input logic with_irq);
    acc(1'b0, 3'd1, 16'h0008);
    acc(1'b0, 3'd0, 16'h0000);
    cmd_stop = 1'b1;
    tmr_irq  = with_irq;
    cyc(1);
    cmd_stop = 1'b0;
    chk("stp_no_tick", 32'(tick_pulse), 32'd0);
    cyc(1);
    tmr_irq  = 1'b0;
    chk("stpclr_no_tick", 32'(tick_pulse), 32'd0);
    cyc(1);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ready", 32'(cmd_ready), 32'd1);
    chk("stop_count", 32'(tick_count), 32'(cnt));
    cyc(1);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_period = 32'd0;
    cmd_cont   = 1'b0;
    cmd_stop   = 1'b0;
    tmr_irq    = 1'b0;
`ifdef TIMER_CTRL_SNAPSHOT_EN
    snap_req   = 1'b0;
`endif
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick_pulse), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(tick_count), 32'd0);
    chk("rst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
        {1'b0, 1'b1, 3'd0, 16'h0000});
`ifdef TIMER_CTRL_SNAPSHOT_EN
    chk("rst_snap", snap_value, 32'd0);
    chk("rst_snap_valid", 32'(snap_valid), 32'd0);
`endif
    cyc(1);
    reset_n = 1'b1;
    cyc(2);

    // stop and valid in IDLE are ignored
    cmd_stop = 1'b1;
    cyc(2);
    cmd_stop = 1'b0;
    chk("idle_stop_ignored", 32'(busy), 32'd0);

    // periodic programming sequence, stray valid in RUN ignored
    start(32'h0001_86A0, 1'b1, 32'h0001_86A0);
    cyc(1);
    chk("run_busy", 32'(busy), 32'd1);
    cmd_valid  = 1'b1;
    cmd_period = 32'h0000_0777;
    cyc(2);
    cmd_valid  = 1'b0;
    chk("run_stays", 32'(cmd_ready), 32'd0);
    stop(1'b0);

    // one-shot, 50 clock period
    start(32'd49, 1'b0, 32'd49);
    cyc(46);
    irq(1'b0);
    chk("oneshot_ready", 32'(cmd_ready), 32'd1);

    // zero period is promoted to one
    start(32'd0, 1'b0, 32'd1);
    stop(1'b0);

    // five periodic timeouts, then stop
    start(32'd100, 1'b1, 32'd100);
    for (int i = 0; i < 5; i++) begin
      cyc(3);
      irq(1'b1);
    end
    stop(1'b0);

    // stop wins over a simultaneous irq
    start(32'd20, 1'b1, 32'd20);
    irq(1'b1);
    stop(1'b1);

    // counter wraps at 2^CW
    start(32'd7, 1'b1, 32'd7);
    for (int i = 0; i < 16; i++)
      irq(1'b1);
    chk("wrap_zero", 32'(tick_count), 32'd0);
    stop(1'b0);

`ifdef TIMER_CTRL_SNAPSHOT_EN
    start(32'd300, 1'b1, 32'd300);
    acc(1'b0, 3'd4, 16'h0000);
    acc(1'b1, 3'd4, 16'h0000);
    acc(1'b1, 3'd5, 16'h0000);
    acc(1'b0, 3'd0, 16'h0000);
    snap_req = 1'b1;
    cyc(1);
    snap_req = 1'b0;
    tmr_irq  = 1'b1;
    cyc(1);
    tmr_irq  = 1'b0;
    cyc(3);
    chk("snap_valid", 32'(snap_valid), 32'd1);
    chk("snap_value", snap_value, 32'h0005_1234);
    cyc(1);
    chk("snap_irq_tick", 32'(tick_pulse), 32'd1);
    chk("snap_valid_low", 32'(snap_valid), 32'd0);
    cyc(1);
    chk("snap_irq_count", 32'(tick_count), 32'd1);
    cnt = 1;
    stop(1'b0);
`endif

    // async reset mid-run clears the count at once
    start(32'd9, 1'b1, 32'd9);
    irq(1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_count", 32'(tick_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cs", 32'(tmr_chipselect), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // reset right after accept abandons the programming sequence
    cmd_valid  = 1'b1;
    cmd_period = 32'd5;
    cyc(1);
    cmd_valid  = 1'b0;
    reset_n    = 1'b0;
    cyc(1);
    reset_n    = 1'b1;
    cyc(5);
    chk("abandon_idle", 32'(busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
